// File: rtl/lemming_world_pkg.sv
// Shared types and defaults for the lemming_world environment model.
// Phase enum plus walker<->world bundles.
package lemmings_pkg;

    typedef enum logic [1:0] {
        WALK = 2'd0,
        FALL = 2'd1,
        DIG  = 2'd2
    } phase_e;

    localparam int DEF_N_COLS      = 16;
    localparam int DEF_START_POS   = 0;
    localparam int DEF_FALL_CYCLES = 4;
    localparam int DEF_DIG_CYCLES  = 3;
    localparam int DEF_MAX_LEVEL   = 3;
    localparam int EVT_W           = 8;

    typedef struct packed {
        logic walk_left;
        logic walk_right;
        logic aaah;
        logic digging;
    } walker_out_t;

    typedef struct packed {
        logic bump_left;
        logic bump_right;
        logic ground;
        logic dig;
    } world_out_t;

endpackage

// File: rtl/lemming_world_if.sv
// Walker <-> world signal bundle.
// master = walker side, slave = world side.
interface lemming_world_if #(
    parameter int N_COLS    = lemmings_pkg::DEF_N_COLS,
    parameter int MAX_LEVEL = lemmings_pkg::DEF_MAX_LEVEL
);
    localparam int PW = $clog2(N_COLS);
    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int EW = lemmings_pkg::EVT_W;

    logic          walk_left;
    logic          walk_right;
    logic          aaah;
    logic          digging;
    logic          dig_cmd;
    logic          bump_left;
    logic          bump_right;
    logic          ground;
    logic          dig;
    logic [PW-1:0] pos;
    logic [LW-1:0] level;
    logic [EW-1:0] fall_count;
    logic [EW-1:0] dig_count;

    modport master (
        output walk_left, walk_right, aaah, digging, dig_cmd,
        input  bump_left, bump_right, ground, dig,
        input  pos, level, fall_count, dig_count
    );

    modport slave (
        input  walk_left, walk_right, aaah, digging, dig_cmd,
        output bump_left, bump_right, ground, dig,
        output pos, level, fall_count, dig_count
    );

endinterface

// File: rtl/lemming_world_sat_cnt.sv
// lw_sat_cnt: W-bit up counter that sticks at all ones.
// Clear has priority over increment.
module lw_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_q
);
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lemming_world.sv
// lemming_world: 1-D track, per-level floor map, fall and dig timing.
// LEMMING_WORLD_EVENT_CNT_EN builds the fall/dig event counters.
module lemming_world
    import lemmings_pkg::*;
#(
    parameter int                N_COLS      = DEF_N_COLS,
    parameter int                START_POS   = DEF_START_POS,
    parameter logic [N_COLS-1:0] INIT_GROUND = {N_COLS{1'b1}},
    parameter int                FALL_CYCLES = DEF_FALL_CYCLES,
    parameter int                DIG_CYCLES  = DEF_DIG_CYCLES,
    parameter int                MAX_LEVEL   = DEF_MAX_LEVEL
) (
    input  logic           clk,
    input  logic           rst_n,
    lemming_world_if.slave w
);
    localparam int PW = $clog2(N_COLS);
    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int FW = $clog2(FALL_CYCLES + 1);
    localparam int DW = $clog2(DIG_CYCLES + 1);

    localparam logic [PW-1:0]     POS_MAX   = PW'(N_COLS - 1);
    localparam logic [PW-1:0]     POS_RST   = PW'(START_POS);
    localparam logic [LW-1:0]     LVL_MAX   = LW'(MAX_LEVEL);
    localparam logic [FW-1:0]     FALL_LAST = FW'(FALL_CYCLES - 1);
    localparam logic [DW-1:0]     DIG_LAST  = DW'(DIG_CYCLES - 1);
    localparam logic [N_COLS-1:0] MAP_ONES  = {N_COLS{1'b1}};
    localparam logic [N_COLS-1:0] MAP_RST   =
        INIT_GROUND | (N_COLS'(1) << START_POS);
    localparam world_out_t        OUT_RST   = '{
        bump_left:  1'b0,
        bump_right: 1'b0,
        ground:     1'b1,
        dig:        1'b0
    };

    walker_out_t       in_s;
    world_out_t        out_d, out_q;
    phase_e            phase_d, phase_q;
    logic [PW-1:0]     pos_d, pos_q;
    logic [LW-1:0]     level_d, level_q;
    logic [N_COLS-1:0] map_d, map_q;

    logic [FW-1:0] fall_cnt, fall_now;
    logic [DW-1:0] dig_cnt, dig_now;
    logic          fall_inc, fall_clr;
    logic          dig_inc, dig_clr;

    assign in_s = {w.walk_left, w.walk_right, w.aaah, w.digging};

    // Progress counts only while we stayed in the same phase.
    assign fall_now = (phase_q == FALL) ? fall_cnt : '0;
    assign dig_now  = (phase_q == DIG)  ? dig_cnt  : '0;

    always_comb begin
        phase_d    = phase_q;
        pos_d      = pos_q;
        level_d    = level_q;
        map_d      = map_q;
        out_d      = out_q;
        out_d.bump_left  = 1'b0;
        out_d.bump_right = 1'b0;
        out_d.dig        = w.dig_cmd;
        fall_inc   = 1'b0;
        fall_clr   = 1'b1;
        dig_inc    = 1'b0;
        dig_clr    = 1'b1;

        if (in_s.aaah) begin
            phase_d = FALL;
            if (fall_now == FALL_LAST) begin
                level_d = (level_q == LVL_MAX) ? LVL_MAX
                                               : level_q + 1'b1;
                map_d = (level_d == LVL_MAX) ? MAP_ONES
                      : (INIT_GROUND | (N_COLS'(1) << pos_q));
                out_d.ground = 1'b1;
            end else begin
                fall_inc     = 1'b1;
                fall_clr     = 1'b0;
                out_d.ground = 1'b0;
            end
        end else if (in_s.digging && out_q.ground) begin
            phase_d = DIG;
            // Bedrock: digging is accepted but makes no progress.
            if (level_q != LVL_MAX) begin
                if (dig_now == DIG_LAST) begin
                    map_d[pos_q] = 1'b0;
                    out_d.ground = 1'b0;
                end else begin
                    dig_inc = 1'b1;
                    dig_clr = 1'b0;
                end
            end
        end else begin
            phase_d = WALK;
            unique case (1'b1)
                in_s.walk_left && !in_s.walk_right: begin
                    if (pos_q == '0) out_d.bump_left = 1'b1;
                    else             pos_d = pos_q - 1'b1;
                end
                in_s.walk_right && !in_s.walk_left: begin
                    if (pos_q == POS_MAX) out_d.bump_right = 1'b1;
                    else                  pos_d = pos_q + 1'b1;
                end
                default: ;
            endcase
            out_d.ground = map_d[pos_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= WALK;
            pos_q   <= POS_RST;
            level_q <= '0;
            map_q   <= MAP_RST;
            out_q   <= OUT_RST;
        end else begin
            phase_q <= phase_d;
            pos_q   <= pos_d;
            level_q <= level_d;
            map_q   <= map_d;
            out_q   <= out_d;
        end
    end

    lw_sat_cnt #(.W(FW)) u_fall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fall_clr),
        .inc   (fall_inc),
        .cnt_q (fall_cnt)
    );

    lw_sat_cnt #(.W(DW)) u_dig_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dig_clr),
        .inc   (dig_inc),
        .cnt_q (dig_cnt)
    );

`ifdef LEMMING_WORLD_EVENT_CNT_EN
    logic             fall_evt, dig_evt;
    logic [EVT_W-1:0] fall_evt_cnt, dig_evt_cnt;

    assign fall_evt = in_s.aaah && !fall_inc;
    assign dig_evt  = (phase_d == DIG) && (level_q != LVL_MAX) && !dig_inc;

    lw_sat_cnt #(.W(EVT_W)) u_fall_evt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (fall_evt),
        .cnt_q (fall_evt_cnt)
    );

    lw_sat_cnt #(.W(EVT_W)) u_dig_evt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (dig_evt),
        .cnt_q (dig_evt_cnt)
    );

    assign w.fall_count = fall_evt_cnt;
    assign w.dig_count  = dig_evt_cnt;
`else
    assign w.fall_count = '0;
    assign w.dig_count  = '0;
`endif

    assign w.bump_left  = out_q.bump_left;
    assign w.bump_right = out_q.bump_right;
    assign w.ground     = out_q.ground;
    assign w.dig        = out_q.dig;
    assign w.pos        = pos_q;
    assign w.level      = level_q;

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: directed scenarios plus randomized
// stimulus against a behavioural model of the track world.
module tb_lemming_world;

    localparam int         NC = 8;
    localparam int         SP = 3;
    localparam logic [7:0] IG = 8'hEF;
    localparam int         FC = 3;
    localparam int         DC = 2;
    localparam int         ML = 2;
`ifdef LEMMING_WORLD_EVENT_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    lemming_world_if #(.N_COLS(NC), .MAX_LEVEL(ML)) w ();

    lemming_world #(
        .N_COLS      (NC),
        .START_POS   (SP),
        .INIT_GROUND (IG),
        .FALL_CYCLES (FC),
        .DIG_CYCLES  (DC),
        .MAX_LEVEL   (ML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural world model
    int m_pos, m_level, m_fall, m_dprog, m_fc, m_dc;
    bit m_ground, m_bl, m_br, m_dig;
    bit m_map [NC];

    task automatic model_reset();
        m_pos = SP; m_level = 0; m_fall = 0; m_dprog = 0;
        m_fc = 0; m_dc = 0;
        m_ground = 1; m_bl = 0; m_br = 0; m_dig = 0;
        for (int i = 0; i < NC; i++) m_map[i] = IG[i];
        m_map[SP] = 1;
    endtask

    task automatic model_step();
        bit wl, wr;
        wl = w.walk_left;
        wr = w.walk_right;
        m_bl = 0;
        m_br = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_dig = w.dig_cmd;
        if (w.aaah) begin
            m_dprog = 0;
            m_fall = m_fall + 1;
            if (m_fall == FC) begin
                m_fall = 0;
                if (m_level < ML) m_level = m_level + 1;
                for (int i = 0; i < NC; i++)
                    m_map[i] = (m_level == ML) ? 1'b1 : IG[i];
                m_map[m_pos] = 1;
                m_ground = 1;
                if (m_fc < 255) m_fc = m_fc + 1;
            end else begin
                m_ground = 0;
            end
        end else if (w.digging && m_ground) begin
            m_fall = 0;
            if (m_level < ML) begin
                m_dprog = m_dprog + 1;
                if (m_dprog == DC) begin
                    m_dprog = 0;
                    m_map[m_pos] = 0;
                    m_ground = 0;
                    if (m_dc < 255) m_dc = m_dc + 1;
                end
            end
        end else begin
            m_fall = 0;
            m_dprog = 0;
            if (wl && !wr) begin
                if (m_pos == 0) m_bl = 1;
                else m_pos = m_pos - 1;
            end else if (wr && !wl) begin
                if (m_pos == NC - 1) m_br = 1;
                else m_pos = m_pos + 1;
            end
            m_ground = m_map[m_pos];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit wl, input bit wr, input bit a,
                         input bit dg, input bit dc);
        w.walk_left  = wl;
        w.walk_right = wr;
        w.aaah       = a;
        w.digging    = dg;
        w.dig_cmd    = dc;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive(0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0, 1);
        tick();
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (w.pos !== 3'd3 || w.level !== 2'd0) begin
            errors++;
            $display("FAIL reset_pos_level: pos=%0d level=%0d, expected 3 0",
                     w.pos, w.level);
        end
        checks++;
        if (w.ground !== 1'b1 || w.bump_left !== 1'b0 ||
            w.bump_right !== 1'b0 || w.dig !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: g=%b bl=%b br=%b dig=%b, expected 1 0 0 0",
                     w.ground, w.bump_left, w.bump_right, w.dig);
        end
        checks++;
        if (w.fall_count !== 8'd0 || w.dig_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: fc=%0d dc=%0d, expected 0 0",
                     w.fall_count, w.dig_count);
        end
    endtask

    task automatic test_walk_left();
        logic [2:0] exp_pos [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
        bit         exp_bl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (w.pos !== exp_pos[i] || w.bump_left !== exp_bl[i] ||
                w.ground !== 1'b1) begin
                errors++;
                $display("FAIL walk_left[%0d]: pos=%0d bl=%b g=%b, expected %0d %b 1",
                         i, w.pos, w.bump_left, w.ground, exp_pos[i], exp_bl[i]);
            end
        end
        drive(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (w.bump_left !== 1'b0 || w.pos !== 3'd0) begin
            errors++;
            $display("FAIL bump_left_pulse: bl=%b pos=%0d, expected 0 0",
                     w.bump_left, w.pos);
        end
    endtask

    task automatic test_walk_right_wall();
        logic [2:0] exp_pos [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        bit         exp_g   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit         exp_br  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (w.pos !== exp_pos[i] || w.ground !== exp_g[i] ||
                w.bump_right !== exp_br[i]) begin
                errors++;
                $display("FAIL walk_right[%0d]: pos=%0d g=%b br=%b, expected %0d %b %b",
                         i, w.pos, w.ground, w.bump_right,
                         exp_pos[i], exp_g[i], exp_br[i]);
            end
        end
        drive(1, 1, 0, 0, 0);
        tick();
        checks++;
        if (w.pos !== 3'd7 || w.bump_right !== 1'b0 || w.bump_left !== 1'b0) begin
            errors++;
            $display("FAIL both_walk: pos=%0d bl=%b br=%b, expected 7 0 0",
                     w.pos, w.bump_left, w.bump_right);
        end
    endtask

    task automatic test_hole_fall();
        bit exp_g [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        drive(0, 1, 0, 0, 0);
        tick();
        checks++;
        if (w.pos !== 3'd4 || w.ground !== 1'b0) begin
            errors++;
            $display("FAIL hole_step: pos=%0d g=%b, expected 4 0", w.pos, w.ground);
        end
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w.ground !== exp_g[i]) begin
                errors++;
                $display("FAIL fall_ground[%0d]: g=%b, expected %b",
                         i, w.ground, exp_g[i]);
            end
        end
        checks++;
        if (w.level !== 2'd1 || w.pos !== 3'd4 ||
            w.fall_count !== 8'(CNT_EN)) begin
            errors++;
            $display("FAIL fall_done: level=%0d pos=%0d fc=%0d, expected 1 4 %0d",
                     w.level, w.pos, w.fall_count, CNT_EN);
        end
    endtask

    task automatic test_dig();
        drive(0, 0, 0, 1, 0);
        tick();
        checks++;
        if (w.ground !== 1'b1 || w.dig_count !== 8'd0) begin
            errors++;
            $display("FAIL dig_first: g=%b dc=%0d, expected 1 0",
                     w.ground, w.dig_count);
        end
        tick();
        checks++;
        if (w.ground !== 1'b0 || w.dig_count !== 8'(CNT_EN) ||
            w.pos !== 3'd4) begin
            errors++;
            $display("FAIL dig_done: g=%b dc=%0d pos=%0d, expected 0 %0d 4",
                     w.ground, w.dig_count, w.pos, CNT_EN);
        end
        drive(0, 0, 1, 0, 0);
        repeat (3) tick();
        checks++;
        if (w.level !== 2'd2 || w.ground !== 1'b1 ||
            w.fall_count !== 8'(2 * CNT_EN)) begin
            errors++;
            $display("FAIL fall_to_bedrock: level=%0d g=%b fc=%0d, expected 2 1 %0d",
                     w.level, w.ground, w.fall_count, 2 * CNT_EN);
        end
    endtask

    task automatic test_bedrock();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (w.ground !== 1'b1 || w.dig_count !== 8'(CNT_EN)) begin
                errors++;
                $display("FAIL bedrock_dig[%0d]: g=%b dc=%0d, expected 1 %0d",
                         i, w.ground, w.dig_count, CNT_EN);
            end
        end
        drive(0, 0, 1, 0, 0);
        repeat (3) tick();
        checks++;
        if (w.level !== 2'd2 || w.ground !== 1'b1 ||
            w.fall_count !== 8'(3 * CNT_EN)) begin
            errors++;
            $display("FAIL bedrock_fall: level=%0d g=%b fc=%0d, expected 2 1 %0d",
                     w.level, w.ground, w.fall_count, 3 * CNT_EN);
        end
    endtask

    task automatic test_dig_cmd();
        drive(0, 0, 0, 0, 1);
        checks++;
        if (w.dig !== 1'b0) begin
            errors++;
            $display("FAIL dig_cmd_early: dig=%b, expected 0", w.dig);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (w.dig !== 1'b1) begin
            errors++;
            $display("FAIL dig_cmd_delay: dig=%b, expected 1", w.dig);
        end
        tick();
        checks++;
        if (w.dig !== 1'b0) begin
            errors++;
            $display("FAIL dig_cmd_pulse: dig=%b, expected 0", w.dig);
        end
    endtask

    task automatic test_partial_dig();
        do_reset();
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        checks++;
        if (w.ground !== 1'b1 || w.dig_count !== 8'd0) begin
            errors++;
            $display("FAIL partial_dig: g=%b dc=%0d, expected 1 0",
                     w.ground, w.dig_count);
        end
        tick();
        checks++;
        if (w.ground !== 1'b0 || w.dig_count !== 8'(CNT_EN)) begin
            errors++;
            $display("FAIL dig_restart: g=%b dc=%0d, expected 0 %0d",
                     w.ground, w.dig_count, CNT_EN);
        end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        drive(0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if (w.ground !== 1'b1 || w.level !== 2'd0 || w.pos !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_fall: g=%b level=%0d pos=%0d, expected 1 0 3",
                     w.ground, w.level, w.pos);
        end
        repeat (2) tick();
        checks++;
        if (w.level !== 2'd0 || w.ground !== 1'b0) begin
            errors++;
            $display("FAIL fall_restart_early: level=%0d g=%b, expected 0 0",
                     w.level, w.ground);
        end
        tick();
        checks++;
        if (w.level !== 2'd1 || w.ground !== 1'b1) begin
            errors++;
            $display("FAIL fall_restart_done: level=%0d g=%b, expected 1 1",
                     w.level, w.ground);
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int          sel, len;
        bit          dc;
        logic [24:0] got, exp;
        do_reset();
        for (int s = 0; s < 80; s++) begin
            sel = $urandom_range(0, 7);
            len = $urandom_range(1, 5);
            for (int c = 0; c < len; c++) begin
                dc = 1'($urandom_range(0, 1));
                case (sel)
                    0: drive(0, 0, 0, 0, dc);
                    1: drive(1, 0, 0, 0, dc);
                    2: drive(0, 1, 0, 0, dc);
                    3: drive(1, 1, 0, 0, dc);
                    4: drive(0, 0, 1, 0, dc);
                    5: drive(0, 0, 0, 1, dc);
                    6: drive(1, 0, 0, 1, dc);
                    default: drive(0, 1, 1, 1, dc);
                endcase
                rst_n = ($urandom_range(0, 79) != 0);
                tick();
                got = {w.pos, w.level, w.ground, w.bump_left, w.bump_right,
                       w.dig, w.fall_count, w.dig_count};
                exp = {3'(m_pos), 2'(m_level), m_ground, m_bl, m_br, m_dig,
                       8'(CNT_EN * m_fc), 8'(CNT_EN * m_dc)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got=%h expected=%h",
                             s, c, got, exp);
                end
            end
        end
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_walk_left();
        test_walk_right_wall();
        test_hole_fall();
        test_dig();
        test_bedrock();
        test_dig_cmd();
        test_partial_dig();
        test_reset_mid_fall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
